trap_controller: RTL

- Sequential trap/interrupt unit for the vesp RV32 core. Sits beside the decode controller and CSR datapath.
- Detects ECALL, EBREAK, illegal instructions, misaligned load/store addresses and a parametrised set of external interrupts.
- Owns the machine trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause, mtval) and runs a small FSM that stalls the pipeline, saves state and redirects the PC, including MRET return.

---
 rtl/trap_pkg.sv | 52 +++++
 rtl/trap_controller_if.sv | 34 +++
 rtl/trap_csr_file.sv | 118 +++++++++++
 rtl/trap_controller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared constants for the vesp machine-mode trap unit: CSR addresses,
// exception cause codes, FSM encoding and the fixed SYSTEM encodings.
package trap_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [4:0] CAUSE_ILLEGAL          = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
    localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;
    localparam logic [4:0] CAUSE_IRQ_BASE         = 5'd16;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSN_MRET   = 32'h3020_0073;

    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // True for the CSR addresses this unit actually backs with storage.
    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // True for the RV32I major opcodes (instruction[6:2]) the core executes.
    function automatic logic opcode_legal(input logic [4:0] op);
        case (op)
            5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000, 5'b11000,
            5'b01101, 5'b00101, 5'b11011, 5'b00011, 5'b11100: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Decode-side bundle between the core pipeline and the trap controller.
interface trap_controller_if #(
    parameter int XLEN      = 32,
    parameter int IRQ_COUNT = 4
);
    logic [31:0]          instruction;
    logic [XLEN-1:0]      pc;
    logic                 instrValid;
    logic [XLEN-1:0]      memAddr;
    logic                 memRd;
    logic                 memWr;
    logic [IRQ_COUNT-1:0] irq;
    logic                 csrWr;
    logic [11:0]          csrAddr;
    logic [XLEN-1:0]      csrWrData;
    logic [XLEN-1:0]      csrRdData;
    logic                 stall;
    logic                 trapTaken;
    logic [XLEN-1:0]      trapPC;

    // Core pipeline side.
    modport master (
        output instruction, pc, instrValid, memAddr, memRd, memWr, irq,
               csrWr, csrAddr, csrWrData,
        input  csrRdData, stall, trapTaken, trapPC
    );

    // Trap controller side.
    modport slave (
        input  instruction, pc, instrValid, memAddr, memRd, memWr, irq,
               csrWr, csrAddr, csrWrData,
        output csrRdData, stall, trapTaken, trapPC
    );
endinterface

// File: rtl/trap_csr_file.sv
// Machine trap CSR storage: trap entry and MRET updates take priority over
// software writes, so a write issued alongside a trap is dropped.
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              IRQ_COUNT   = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IRQ_COUNT-1:0] irq,
    input  logic                 csr_we,
    input  logic [11:0]          csr_addr,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    input  logic                 trap_en,
    input  logic [XLEN-1:0]      trap_cause,
    input  logic [XLEN-1:0]      trap_epc,
    input  logic [XLEN-1:0]      trap_tval,
    input  logic                 mret_en,
    output logic                 mstatus_mie,
    output logic [IRQ_COUNT-1:0] irq_en,
    output logic [XLEN-1:0]      mtvec,
    output logic [XLEN-1:0]      mepc
);

    logic                 mie_bit_q, mie_bit_d;
    logic                 mpie_q, mpie_d;
    logic [IRQ_COUNT-1:0] irq_en_q, irq_en_d;
    logic [XLEN-1:0]      mtvec_q, mtvec_d;
    logic [XLEN-1:0]      mepc_q, mepc_d;
    logic [XLEN-1:0]      mcause_q, mcause_d;
    logic [XLEN-1:0]      mtval_q, mtval_d;

    // Next-state for every CSR: trap entry, then MRET, then software write.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        mie_bit_d = mie_bit_q;
        mpie_d    = mpie_q;
        irq_en_d  = irq_en_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mtval_d   = mtval_q;
        if (trap_en) begin
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
            mepc_d    = trap_epc;
            mcause_d  = trap_cause;
            mtval_d   = trap_tval;
        end else if (mret_en) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_bit_d = csr_wdata[MSTATUS_MIE_BIT];
                    mpie_d    = csr_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:    irq_en_d = csr_wdata[16 +: IRQ_COUNT];
                // Reserved modes 1x collapse to direct.
                CSR_MTVEC:  mtvec_d  = {csr_wdata[XLEN-1:2],
                                        (csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
                CSR_MEPC:   mepc_d   = {csr_wdata[XLEN-1:2], 2'b00};
                CSR_MCAUSE: mcause_d = csr_wdata;
                CSR_MTVAL:  mtval_d  = csr_wdata;
                default:    ;  // mip and unimplemented addresses are not writable
            endcase
        end
    end

    // CSR registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            mie_bit_q <= 1'b0;
            mpie_q    <= 1'b0;
            irq_en_q  <= '0;
            mtvec_q   <= MTVEC_RESET;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtval_q   <= '0;
        end else begin
            mie_bit_q <= mie_bit_d;
            mpie_q    <= mpie_d;
            irq_en_q  <= irq_en_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mtval_q   <= mtval_d;
        end
    end

    // Combinational read mux; mie/mip place the interrupt lines at bit 16.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE_BIT]  = mie_bit_q;
                csr_rdata[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_MIE:    csr_rdata = {{(XLEN-IRQ_COUNT){1'b0}}, irq_en_q} << 16;
            CSR_MIP:    csr_rdata = {{(XLEN-IRQ_COUNT){1'b0}}, irq} << 16;
            CSR_MTVEC:  csr_rdata = mtvec_q;
            CSR_MEPC:   csr_rdata = mepc_q;
            CSR_MCAUSE: csr_rdata = mcause_q;
            CSR_MTVAL:  csr_rdata = mtval_q;
            default:    csr_rdata = '0;
        endcase
    end

    assign mstatus_mie = mie_bit_q;
    assign irq_en      = irq_en_q;
    assign mtvec       = mtvec_q;
    assign mepc        = mepc_q;

endmodule

// File: rtl/trap_controller.sv
// Trap/interrupt unit: prioritises trap causes for the instruction in decode,
// stalls it in the detection cycle and redirects the PC one cycle later.
module trap_controller
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              IRQ_COUNT   = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    trap_controller_if.slave bus
);

    trap_state_e          state_q, state_d;
    logic                 trap_taken_q, trap_taken_d;
    logic [XLEN-1:0]      trap_pc_q, trap_pc_d;

    logic                 mstatus_mie;
    logic [IRQ_COUNT-1:0] irq_en;
    logic [XLEN-1:0]      mtvec, mepc;

    logic                 take_trap, take_mret, trap_is_irq;
    logic [4:0]           trap_code;
    logic [XLEN-1:0]      trap_tval, trap_cause, trap_base, redirect_pc;

    // Decode the trap sources and pick the highest-priority one.
    always_comb begin
        logic [4:0] opcode;
        logic [2:0] funct3;
        logic       is_system, is_csr_op, illegal, misaligned;
        logic       irq_hit;
        logic [4:0] irq_idx;

        opcode    = bus.instruction[6:2];
        funct3    = bus.instruction[14:12];
        is_system = (bus.instruction[1:0] == 2'b11) && (opcode == OPC_SYSTEM);
        // funct3 000 and 100 are the only SYSTEM encodings that are not CSR ops.
        is_csr_op = is_system && (funct3[1:0] != 2'b00);
        illegal   = (bus.instruction[1:0] != 2'b11) || !opcode_legal(opcode)
                 || (is_system && funct3 == 3'b100)
                 || (is_csr_op && !csr_implemented(bus.instruction[31:20]));
        misaligned = ((funct3[1:0] == 2'b01) && bus.memAddr[0])
                  || ((funct3[1:0] == 2'b10) && (bus.memAddr[1:0] != 2'b00));

        // Scan downwards so the lowest pending line wins.
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (mstatus_mie && irq_en[i] && bus.irq[i]) begin
                irq_hit = 1'b1;
                irq_idx = 5'(i);
            end
        end

        take_trap   = 1'b0;
        take_mret   = 1'b0;
        trap_is_irq = 1'b0;
        trap_code   = '0;
        trap_tval   = '0;
        if (!reset && state_q == ST_RUN && bus.instrValid) begin
            if (irq_hit) begin
                take_trap   = 1'b1;
                trap_is_irq = 1'b1;
                trap_code   = CAUSE_IRQ_BASE + irq_idx;
            end else if (illegal) begin
                take_trap = 1'b1;
                trap_code = CAUSE_ILLEGAL;
                trap_tval = bus.instruction;
            end else if (bus.instruction == INSN_ECALL) begin
                take_trap = 1'b1;
                trap_code = CAUSE_ECALL_M;
            end else if (bus.instruction == INSN_EBREAK) begin
                take_trap = 1'b1;
                trap_code = CAUSE_BREAKPOINT;
                trap_tval = bus.pc;
            end else if (bus.memRd && misaligned) begin
                take_trap = 1'b1;
                trap_code = CAUSE_LOAD_MISALIGNED;
                trap_tval = bus.memAddr;
            end else if (bus.memWr && misaligned) begin
                take_trap = 1'b1;
                trap_code = CAUSE_STORE_MISALIGNED;
                trap_tval = bus.memAddr;
            end else if (bus.instruction == INSN_MRET) begin
                take_mret = 1'b1;
            end
        end
    end

    assign trap_cause = {trap_is_irq, {(XLEN-6){1'b0}}, trap_code};
    assign trap_base  = {mtvec[XLEN-1:2], 2'b00};

    // Redirect target: mepc for MRET, vector slot for interrupts in vectored mode.
    always_comb begin
        if (take_mret)
            redirect_pc = mepc;
        else if (trap_is_irq && mtvec[1:0] == 2'b01)
            redirect_pc = trap_base + {{(XLEN-7){1'b0}}, trap_code, 2'b00};
        else
            redirect_pc = trap_base;
    end

    // FSM next state: RUN -> REDIRECT on trap/MRET, REDIRECT always back to RUN.
    always_comb begin
        state_d      = state_q;
        trap_taken_d = 1'b0;
        trap_pc_d    = trap_pc_q;
        case (state_q)
            ST_RUN: begin
                if (take_trap || take_mret) begin
                    state_d      = ST_REDIRECT;
                    trap_taken_d = 1'b1;
                    trap_pc_d    = redirect_pc;
                end
            end
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    // FSM state and registered redirect outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            trap_taken_q <= 1'b0;
            trap_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            trap_taken_q <= trap_taken_d;
            trap_pc_q    <= trap_pc_d;
        end
    end

    trap_csr_file #(
        .XLEN        (XLEN),
        .IRQ_COUNT   (IRQ_COUNT),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clk         (clk),
        .reset       (reset),
        .irq         (bus.irq),
        .csr_we      (bus.csrWr && state_q == ST_RUN),
        .csr_addr    (bus.csrAddr),
        .csr_wdata   (bus.csrWrData),
        .csr_rdata   (bus.csrRdData),
        .trap_en     (take_trap),
        .trap_cause  (trap_cause),
        .trap_epc    ({bus.pc[XLEN-1:2], 2'b00}),
        .trap_tval   (trap_tval),
        .mret_en     (take_mret),
        .mstatus_mie (mstatus_mie),
        .irq_en      (irq_en),
        .mtvec       (mtvec),
        .mepc        (mepc)
    );

    // The offending instruction is held in the detection cycle and the redirect cycle.
    assign bus.stall     = take_trap || take_mret || (state_q == ST_REDIRECT);
    assign bus.trapTaken = trap_taken_q;
    assign bus.trapPC    = trap_pc_q;

endmodule
